// File: rtl/decode_stage.sv
// decode_stage: instruction decode for the 8-bit pipelined CPU.
// Accepts 16-bit instructions from fetch and reads the 4-entry register file.
// A busy scoreboard blocks reads of registers that still have a write pending.
// One decoded bundle is registered toward execute.
// Optional feature macro: DECODE_WB_BYPASS_EN. When it is defined, a source that
// is being written back in the same cycle is read from wb_data and is not a hazard.
module decode_stage #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [15:0]         in_instr,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]    op1,
  output logic [WIDTH-1:0]    op2,
  output logic [1:0]          rd,
  output logic                wr_en,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [1:0]          wb_addr,
  input  logic [WIDTH-1:0]    wb_data,
  output logic                halted
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [WIDTH-1:0]    r_regs [4];
  logic [3:0]          r_busy;
  logic                r_started;
  logic                r_halted;
  logic                r_out_valid;
  logic [OP_WIDTH-1:0] r_alu_op;
  logic [WIDTH-1:0]    r_op1;
  logic [WIDTH-1:0]    r_op2;
  logic [1:0]          r_rd;
  logic                r_wr_en;

  logic [2:0]          w_op;
  logic                w_imm_f;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs1;
  logic [1:0]          w_rs2;
  logic [7:0]          w_imm8;
  logic                w_is_alu;
  logic                w_use_rs1;
  logic                w_use_rs2;
  logic                w_rs1_busy;
  logic                w_rs2_busy;
  logic [WIDTH-1:0]    w_rs1_val;
  logic [WIDTH-1:0]    w_rs2_val;
  logic                w_hazard;
  logic                w_accept;
  logic [OP_WIDTH-1:0] w_dec_alu;
  logic [WIDTH-1:0]    w_dec_op1;
  logic [WIDTH-1:0]    w_dec_op2;
  logic                w_dec_wr;
  logic [3:0]          w_busy_nxt;

  assign w_op    = in_instr[15:13];
  assign w_imm_f = in_instr[12];
  assign w_rd    = in_instr[11:10];
  assign w_rs1   = in_instr[9:8];
  assign w_rs2   = in_instr[7:6];
  assign w_imm8  = in_instr[7:0];

  // ADD/SUB/AND/OR/XOR are the only instructions that read sources.
  assign w_is_alu  = (w_op != OP_NOP) && (w_op != OP_LI) && (w_op != OP_HALT);
  assign w_use_rs1 = w_is_alu;
  assign w_use_rs2 = w_is_alu && !w_imm_f;

`ifdef DECODE_WB_BYPASS_EN
  logic w_byp1;
  logic w_byp2;
  assign w_byp1     = wb_en && (wb_addr == w_rs1);
  assign w_byp2     = wb_en && (wb_addr == w_rs2);
  assign w_rs1_busy = r_busy[w_rs1] && !w_byp1;
  assign w_rs2_busy = r_busy[w_rs2] && !w_byp2;
  assign w_rs1_val  = w_byp1 ? wb_data : r_regs[w_rs1];
  assign w_rs2_val  = w_byp2 ? wb_data : r_regs[w_rs2];
`else
  // Without bypass a writeback only becomes visible after its clock edge.
  assign w_rs1_busy = r_busy[w_rs1];
  assign w_rs2_busy = r_busy[w_rs2];
  assign w_rs1_val  = r_regs[w_rs1];
  assign w_rs2_val  = r_regs[w_rs2];
`endif

  assign w_hazard = (w_use_rs1 && w_rs1_busy) || (w_use_rs2 && w_rs2_busy);

  // r_started keeps in_ready low until the first edge after reset release.
  // flush squashes the incoming instruction as well as the registered bundle.
  assign in_ready = r_started && !r_halted && !flush && !w_hazard &&
                    (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Decode the incoming instruction into an ALU bundle. HALT is emitted as a NOP.
  always_comb begin
    w_dec_alu = '0;
    w_dec_op1 = '0;
    w_dec_op2 = '0;
    w_dec_wr  = 1'b0;
    if (w_is_alu) begin
      w_dec_alu = OP_WIDTH'(w_op);
      w_dec_op1 = w_rs1_val;
      w_dec_op2 = w_imm_f ? WIDTH'(w_imm8) : w_rs2_val;
      w_dec_wr  = 1'b1;
    end else if (w_op == OP_LI) begin
      w_dec_alu = OP_WIDTH'(3'b001);
      w_dec_op2 = WIDTH'(w_imm8);
      w_dec_wr  = 1'b1;
    end
  end

  // Compute the next scoreboard value. A set for an accepted bundle wins over a
  // same-cycle writeback clear of the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) w_busy_nxt[wb_addr] = 1'b0;
    if (flush && r_out_valid && r_wr_en) w_busy_nxt[r_rd] = 1'b0;
    if (w_accept && w_dec_wr) w_busy_nxt[w_rd] = 1'b1;
  end

  // Update the scoreboard, the start flag and the sticky halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_started <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_started <= 1'b1;
      if (w_accept && (w_op == OP_HALT)) r_halted <= 1'b1;
    end
  end

  // Write the register file from the writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Hold the output bundle until execute takes it. flush drops it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_op    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rd        <= '0;
      r_wr_en     <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_alu_op <= w_dec_alu;
        r_op1    <= w_dec_op1;
        r_op2    <= w_dec_op2;
        r_rd     <= w_rd;
        r_wr_en  <= w_dec_wr;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_op    = r_alu_op;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign rd        = r_rd;
  assign wr_en     = r_wr_en;
  assign halted    = r_halted;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage.
// A per-cycle reference model predicts the design's outputs, and every cycle is
// compared against that prediction. Directed scenarios run first, then random traffic.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_op;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic [1:0]  rd;
  logic        wr_en;
  logic        flush;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        halted;

  decode_stage #(.WIDTH(8), .OP_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .op1(op1), .op2(op2), .rd(rd), .wr_en(wr_en),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural registers, pending writes, the bundle in flight.
  logic [7:0] m_reg [4];
  logic [3:0] m_busy;
  logic       m_ov, m_halt, m_started;
  logic [2:0] e_alu;
  logic [7:0] e_op1, e_op2;
  logic [1:0] e_rd;
  logic       e_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [1:0] d,
                                        input logic [1:0] s1, input logic [1:0] s2);
    return {op, 1'b0, d, s1, s2, 6'b0};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [1:0] d,
                                        input logic [1:0] s1, input logic [7:0] imm);
    return {op, 1'b1, d, s1, imm};
  endfunction

  // Run one clock cycle. Drive the inputs, check the predicted outputs, then advance the model.
  task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                      input logic fl, input logic we, input logic [1:0] wa,
                      input logic [7:0] wd, output logic acc);
    logic [2:0] op;
    logic       use1, use2, bz1, bz2, er;
    logic [1:0] s1, s2;
    logic [7:0] v1, v2;
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    op   = ins[15:13];
    use1 = (op >= 3'd1) && (op <= 3'd5);
    use2 = use1 && !ins[12];
    s1 = ins[9:8];
    s2 = ins[7:6];
    bz1 = m_busy[s1]; bz2 = m_busy[s2];
    v1 = m_reg[s1];   v2 = m_reg[s2];
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == s1) begin bz1 = 1'b0; v1 = wd; end
    if (we && wa == s2) begin bz2 = 1'b0; v2 = wd; end
`endif
    er = m_started && !m_halt && !fl && !((use1 && bz1) || (use2 && bz2)) && (!m_ov || ordy);
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, m_ov);
    check("halted", halted, m_halt);
    if (m_ov) begin
      check("alu_op", alu_op, e_alu);
      check("op1", op1, e_op1);
      check("op2", op2, e_op2);
      check("rd", rd, e_rd);
      check("wr_en", wr_en, e_wr);
    end
    acc = v && er;
    if (we) m_busy[wa] = 1'b0;
    if (fl && m_ov && e_wr) m_busy[e_rd] = 1'b0;
    if (fl) m_ov = 1'b0;
    else if (acc) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    if (acc) begin
      e_rd = ins[11:10];
      if (use1) begin
        e_alu = op; e_op1 = v1; e_op2 = ins[12] ? ins[7:0] : v2; e_wr = 1'b1;
      end else if (op == 3'd6) begin
        e_alu = 3'd1; e_op1 = 8'h00; e_op2 = ins[7:0]; e_wr = 1'b1;
      end else begin
        e_alu = 3'd0; e_op1 = 8'h00; e_op2 = 8'h00; e_wr = 1'b0;
      end
      if (e_wr) m_busy[e_rd] = 1'b1;
      if (op == 3'd7) m_halt = 1'b1;
    end
    if (we) m_reg[wa] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_alu_op", alu_op, 3'd0);
    check("rst_op1", op1, 8'h00);
    check("rst_op2", op2, 8'h00);
    check("rst_rd", rd, 2'd0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_halted", halted, 1'b0);
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_busy = 4'h0; m_ov = 1'b0; m_halt = 1'b0; m_started = 1'b0;
    e_alu = 3'd0; e_op1 = 8'h00; e_op2 = 8'h00; e_rd = 2'd0; e_wr = 1'b0;
    in_valid = 1'b1; in_instr = enc_i(3'd6, 2'd0, 2'd0, 8'h11);
    out_ready = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = 2'd0; wb_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_after_release", in_ready, 1'b0);
    m_started = 1'b1;
  endtask

  logic acc;
  int   tries;
  logic [15:0] ri;
  logic [2:0]  rop;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    do_reset();

    // LI r1,5 then ADD r2,r1,#3 which stalls until r1 is written back.
    step(1, enc_i(3'd6, 2'd1, 2'd0, 8'h05), 1, 0, 0, 2'd0, 8'h00, acc);
    check("li_acc", acc, 1'b1);
    tries = 0;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      step(1, enc_i(3'd1, 2'd2, 2'd1, 8'h03), 1, 0, (k == 2), 2'd1, 8'h05, acc);
      tries = k + 1;
    end
`ifdef DECODE_WB_BYPASS_EN
    check("add_issue_cycle", tries, 3);
`else
    check("add_issue_cycle", tries, 4);
`endif
    step(0, 16'h0000, 0, 0, 0, 2'd0, 8'h00, acc);
    check("add_alu_op", alu_op, 3'd1);
    check("add_op1", op1, 8'h05);
    check("add_op2", op2, 8'h03);
    step(0, 16'h0000, 1, 0, 1, 2'd2, 8'h08, acc);

    // XOR r3,r0,r0 is held for 3 cycles, and the next instruction is taken when out_ready rises.
    step(1, enc_r(3'd5, 2'd3, 2'd0, 2'd0), 1, 0, 0, 2'd0, 8'h00, acc);
    for (int k = 0; k < 3; k++) begin
      step(1, enc_i(3'd6, 2'd0, 2'd0, 8'h44), 0, 0, 0, 2'd0, 8'h00, acc);
      check("hold_no_acc", acc, 1'b0);
    end
    step(1, enc_i(3'd6, 2'd0, 2'd0, 8'h44), 1, 0, 0, 2'd0, 8'h00, acc);
    check("acc_on_ready", acc, 1'b1);
    step(0, 16'h0000, 1, 0, 1, 2'd3, 8'h06, acc);
    step(0, 16'h0000, 1, 0, 1, 2'd0, 8'h44, acc);

    // Flush a pending ADD r2. Its busy bit is cleared, so a later read of r2 does not stall.
    step(1, enc_r(3'd1, 2'd2, 2'd0, 2'd0), 0, 0, 0, 2'd0, 8'h00, acc);
    step(0, 16'h0000, 0, 1, 0, 2'd0, 8'h00, acc);
    step(1, enc_r(3'd1, 2'd3, 2'd2, 2'd2), 1, 0, 0, 2'd0, 8'h00, acc);
    check("flush_no_stall", acc, 1'b1);
    step(0, 16'h0000, 1, 0, 1, 2'd3, 8'h00, acc);

    // A writeback of r1 in the same cycle that LI r1 is accepted leaves r1 busy.
    step(1, enc_i(3'd6, 2'd1, 2'd0, 8'h22), 1, 0, 1, 2'd1, 8'h99, acc);
    check("li_r1_acc", acc, 1'b1);
    step(1, enc_i(3'd1, 2'd0, 2'd1, 8'h00), 1, 0, 0, 2'd0, 8'h00, acc);
    check("set_wins_stall", acc, 1'b0);
    step(0, 16'h0000, 1, 0, 1, 2'd1, 8'h22, acc);

    // HALT is emitted as a NOP and blocks all further input.
    step(1, {3'd7, 13'h1abc}, 1, 0, 0, 2'd0, 8'h00, acc);
    check("halt_acc", acc, 1'b1);
    step(1, enc_i(3'd6, 2'd0, 2'd0, 8'h01), 1, 0, 0, 2'd0, 8'h00, acc);
    check("halt_bundle_wr", wr_en, 1'b0);
    check("halt_bundle_op", alu_op, 3'd0);
    for (int k = 0; k < 4; k++)
      step(1, enc_i(3'd6, 2'd0, 2'd0, 8'h01), 1, 0, 0, 2'd0, 8'h00, acc);

    // Random traffic, with a reset in the middle of the stream every 150 cycles.
    do_reset();
    for (int n = 0; n < 1200; n++) begin
      if (n % 150 == 149) do_reset();
      rop = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 59) == 0) rop = 3'd7;
      ri = {rop, 13'($urandom)};
      step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           2'($urandom), 8'($urandom), acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
